return_address_stack: RTL and testbench

- Hardware call stack that supplies the return address for RET.
- A CALL pushes the return address (pc_cur+1). A RET pops it.
- top_address feeds the PC-next selection logic on its PCSrc=3 (RET) path.
- Sits beside the PC register in the multi-cycle datapath. push and pop are driven by the control unit in the cycle the jump/return commits.

---
 rtl/return_address_stack_if.sv | 30 +++
 rtl/return_address_stack.sv | 106 ++++++++++
 tb/tb_return_address_stack.sv | 127 ++++++++++++
 3 files changed

// File: rtl/return_address_stack_if.sv
// Return address stack bundle: control-unit push/pop request and
// stack status. master = control unit, slave = stack.
interface return_address_stack_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [AW-1:0] push_addr;
    logic          pop;
    logic [AW-1:0] top_address;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output push, push_addr, pop,
        input  top_address, empty, full, count,
        input  overflow, underflow
    );

    modport slave (
        input  push, push_addr, pop,
        output top_address, empty, full, count,
        output overflow, underflow
    );
endinterface

// File: rtl/return_address_stack.sv
// Hardware call stack feeding the RET path of PC-next selection.
// Ports: clk, reset (sync, active-high), ras (slave: push/pop/push_addr
// in; top_address/empty/full/count/overflow/underflow out).
// RAS_CIRCULAR_EN: push while full overwrites the oldest entry.
module return_address_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    return_address_stack_if.slave ras
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] mem_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          wr_en;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] top_idx;
    logic          is_empty, is_full;
    logic          do_replace, do_push, push_full;
    logic          do_pop, pop_empty;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign top_idx  = sp_q - 1'b1;

    // Mutually exclusive operation decode. push+pop on an empty
    // stack degenerates to a plain push.
    assign do_replace = ras.push & ras.pop & ~is_empty;
    assign do_push    = ras.push & (ras.pop ? is_empty : ~is_full);
    assign push_full  = ras.push & ~ras.pop & is_full;
    assign do_pop     = ras.pop & ~ras.push & ~is_empty;
    assign pop_empty  = ras.pop & ~ras.push & is_empty;

    always_comb begin
        sp_d        = sp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_idx      = sp_q;
        unique case (1'b1)
            do_replace: begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
            do_push: begin
                wr_en   = 1'b1;
                sp_d    = sp_q + 1'b1;
                count_d = count_q + 1'b1;
            end
            push_full: begin
                overflow_d = 1'b1;
`ifdef RAS_CIRCULAR_EN
                // Oldest entry sits at sp when full; overwrite it.
                wr_en = 1'b1;
                sp_d  = sp_q + 1'b1;
`endif
            end
            do_pop: begin
                sp_d    = sp_q - 1'b1;
                count_d = count_q - 1'b1;
            end
            pop_empty: begin
                underflow_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem_q[wr_idx] <= ras.push_addr;
        end
    end

    assign ras.top_address = is_empty ? '0 : mem_q[top_idx];
    assign ras.empty       = is_empty;
    assign ras.full        = is_full;
    assign ras.count       = count_q;
    assign ras.overflow    = overflow_q;
    assign ras.underflow   = underflow_q;
endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack (DEPTH=8, AW=32).
// Honours RAS_CIRCULAR_EN to select the expected full-push behaviour.
module tb_return_address_stack;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    return_address_stack_if #(.DEPTH(8), .AW(32)) ras_if ();

    return_address_stack #(.DEPTH(8), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ras   (ras_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock of stimulus; returns #1 after the rising edge.
    task automatic op(input bit rst, input bit pu, input bit po,
                      input logic [31:0] a);
        reset            = rst;
        ras_if.push      = pu;
        ras_if.pop       = po;
        ras_if.push_addr = a;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        ras_if.push = 1'b0;
        ras_if.pop  = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset            = 1'b1;
        ras_if.push      = 1'b0;
        ras_if.pop       = 1'b0;
        ras_if.push_addr = '0;
        @(posedge clk);
        #1;
        op(1, 0, 0, 0);
        op(0, 0, 0, 0);

        chk("rst_count", 32'(ras_if.count), 0);
        chk("rst_empty", 32'(ras_if.empty), 1);
        chk("rst_full", 32'(ras_if.full), 0);
        chk("rst_top", ras_if.top_address, 0);
        chk("rst_ovf", 32'(ras_if.overflow), 0);
        chk("rst_unf", 32'(ras_if.underflow), 0);

        op(0, 1, 0, 32'h10);
        op(0, 1, 0, 32'h20);
        op(0, 1, 0, 32'h30);
        chk("p3_top", ras_if.top_address, 32'h30);
        chk("p3_count", 32'(ras_if.count), 3);
        op(0, 0, 1, 0);
        chk("pop1_top", ras_if.top_address, 32'h20);
        op(0, 0, 1, 0);
        chk("pop2_top", ras_if.top_address, 32'h10);
        op(0, 0, 1, 0);
        chk("pop3_top", ras_if.top_address, 0);
        chk("pop3_empty", 32'(ras_if.empty), 1);

        for (int i = 0; i < 8; i++) op(0, 1, 0, 32'h100 + 32'(i));
        chk("fill_full", 32'(ras_if.full), 1);
        chk("fill_top", ras_if.top_address, 32'h107);
        chk("fill_count", 32'(ras_if.count), 8);
        op(0, 1, 0, 32'h200);
        chk("ovf_count", 32'(ras_if.count), 8);
        chk("ovf_flag", 32'(ras_if.overflow), 1);
`ifdef RAS_CIRCULAR_EN
        chk("ovf_top", ras_if.top_address, 32'h200);
        for (int i = 0; i < 7; i++) op(0, 0, 1, 0);
        chk("wrap_last", ras_if.top_address, 32'h101);
`else
        chk("ovf_top", ras_if.top_address, 32'h107);
        for (int i = 0; i < 7; i++) op(0, 0, 1, 0);
        chk("drain_last", ras_if.top_address, 32'h100);
`endif
        op(0, 0, 1, 0);
        chk("drain_empty", 32'(ras_if.empty), 1);
        chk("drain_unf", 32'(ras_if.underflow), 0);

        op(0, 0, 1, 0);
        chk("unf_count", 32'(ras_if.count), 0);
        chk("unf_top", ras_if.top_address, 0);
        chk("unf_flag", 32'(ras_if.underflow), 1);
        op(0, 0, 0, 0);
        chk("unf_sticky", 32'(ras_if.underflow), 1);
        op(1, 0, 0, 0);
        chk("unf_clr", 32'(ras_if.underflow), 0);
        chk("ovf_clr", 32'(ras_if.overflow), 0);

        op(0, 1, 0, 32'h40);
        op(0, 1, 0, 32'h50);
        op(0, 1, 1, 32'h60);
        chk("rep_count", 32'(ras_if.count), 2);
        chk("rep_top", ras_if.top_address, 32'h60);
        op(0, 0, 1, 0);
        chk("rep_pop_top", ras_if.top_address, 32'h40);
        op(0, 0, 1, 0);
        op(0, 1, 1, 32'h70);
        chk("pp_empty_cnt", 32'(ras_if.count), 1);
        chk("pp_empty_top", ras_if.top_address, 32'h70);
        chk("pp_empty_unf", 32'(ras_if.underflow), 0);

        op(0, 1, 0, 32'h80);
        op(0, 1, 0, 32'h90);
        chk("pre_rst_cnt", 32'(ras_if.count), 3);
        op(1, 1, 0, 32'hA0);
        chk("rstpush_cnt", 32'(ras_if.count), 0);
        chk("rstpush_empty", 32'(ras_if.empty), 1);
        chk("rstpush_top", ras_if.top_address, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
